// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/lap timer: FSM encoding, time limits
// and a small saturation helper used by the preset load path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned SEC_MAX = 59;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
  } mmss_t;

  function automatic logic [5:0] sat6(input logic [5:0] value, input logic [5:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// First-word-fall-through lap FIFO with sticky overflow flag; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module lap_fifo import stopwatch_pkg::*; #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && (!w_full || i_pop) && !i_flush;

  // NOTE: storage is deliberately not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && w_full && !i_pop) r_overflow <= 1'b1;
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Up/down stopwatch with pause, preset load, countdown completion pulse and
// a lap capture FIFO. Prescaler and time counters live here; laps in lap_fifo.
module stopwatch_lap_timer import stopwatch_pkg::*; #(
  parameter int TICK_DIV  = 100,
  parameter int MIN_MAX   = 59,
  parameter int LAP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       down_mode,
  input  logic       load_en,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       lap,
  input  logic       lap_rd,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       running,
  output logic       done,
  output logic       lap_valid,
  output logic [5:0] lap_min,
  output logic [5:0] lap_sec,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic       lap_overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    MIN_LIM    = 6'(MIN_MAX);
  localparam logic [5:0]    SEC_LIM    = 6'(SEC_MAX);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic          r_down;
  logic          r_done;

  logic  w_tick;
  logic  w_start_req;
  logic  w_pause_req;
  logic  w_time_zero;
  logic  w_at_one;
  logic  w_launch;
  logic  w_enter_done;
  logic  w_push;
  logic  w_pop;
  mmss_t w_lap_in;
  mmss_t w_lap_head;

  // start and pause together cancel each other out
  assign w_start_req = start && !pause;
  assign w_pause_req = pause && !start;
  assign w_time_zero = (r_min == '0) && (r_sec == '0);
  assign w_at_one    = (r_min == '0) && (r_sec == 6'd1);
  assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_enter_done = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_req && !(down_mode && w_time_zero)) begin
            w_state_nxt = ST_RUN;
            w_launch    = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_tick && r_down && w_at_one) begin
            w_state_nxt  = ST_DONE;
            w_enter_done = 1'b1;
          end else if (w_pause_req) begin
            w_state_nxt = ST_PAUSED;
          end
        end
        ST_PAUSED: if (w_start_req) w_state_nxt = ST_RUN;
        ST_DONE:   w_state_nxt = ST_DONE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_down  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_enter_done;
      if (clear) begin
        r_presc <= '0;
        r_sec   <= '0;
        r_min   <= '0;
        r_down  <= 1'b0;
      end else begin
        if (w_launch) begin
          r_presc <= '0;
          r_down  <= down_mode;
        end else if (r_state == ST_RUN) begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end

        if ((r_state == ST_IDLE) && load_en) begin
          r_sec <= sat6(load_sec, SEC_LIM);
          r_min <= sat6(load_min, MIN_LIM);
        end else if (w_tick) begin
          if (r_down) begin
            // the zero case never ticks here: reaching 0:00 moves the FSM to DONE
            if (r_sec == '0) begin
              r_sec <= SEC_LIM;
              r_min <= r_min - 6'd1;
            end else begin
              r_sec <= r_sec - 6'd1;
            end
          end else if (r_sec == SEC_LIM) begin
            r_sec <= '0;
            r_min <= (r_min == MIN_LIM) ? 6'd0 : r_min + 6'd1;
          end else begin
            r_sec <= r_sec + 6'd1;
          end
        end
      end
    end
  end

  assign w_push   = lap && ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && !clear;
  assign w_pop    = lap_rd && !clear;
  assign w_lap_in = '{min: r_min, sec: r_sec};

  lap_fifo #(
    .WIDTH (12),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_flush    (clear),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (w_lap_in),
    .o_valid    (lap_valid),
    .o_data     (w_lap_head),
    .o_count    (lap_count),
    .o_overflow (lap_overflow)
  );

  assign sec     = r_sec;
  assign min     = r_min;
  assign running = (r_state == ST_RUN);
  assign done    = r_done;
  assign lap_min = w_lap_head.min;
  assign lap_sec = w_lap_head.sec;

endmodule
